// File: rtl/tis_ip_seq.sv
// ============================================================================
//  Module      : tis_ip_seq
//  Description : Instruction-pointer sequencer for a TIS-100 execution node.
//                Handles wrap, conditional/relative jumps, stalls and a
//                saturating retired-step counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tis_ip_seq #(
    parameter int AW = 8,
    parameter int DW = 11,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [AW:0]   prog_len,
    input  logic [2:0]    jmp_op,
    input  logic [AW-1:0] jmp_tgt,
    input  logic [DW-1:0] jro_off,
    input  logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          taken,
    output logic          wrap,
    output logic [CW-1:0] step_cnt
);

    // Wide enough that pc + offset can neither overflow nor alias the sign bit
    localparam int c_SW = ((AW > DW) ? AW : DW) + 2;

    localparam logic [2:0] c_OP_JMP = 3'b001;
    localparam logic [2:0] c_OP_JEZ = 3'b010;
    localparam logic [2:0] c_OP_JNZ = 3'b011;
    localparam logic [2:0] c_OP_JGZ = 3'b100;
    localparam logic [2:0] c_OP_JLZ = 3'b101;
    localparam logic [2:0] c_OP_JRO = 3'b110;

    logic [AW-1:0] r_pc;
    logic          r_taken;
    logic          r_wrap;
    logic [CW-1:0] r_cnt;

    logic [AW:0]          w_seq;
    logic                 w_seq_wraps;
    logic [AW-1:0]        w_seq_pc;
    logic [AW-1:0]        w_jmp_pc;
    logic                 w_acc_zero;
    logic                 w_cond;
    logic signed [c_SW-1:0] w_s;
    logic signed [c_SW-1:0] w_last;
    logic [AW-1:0]        w_jro_pc;
    logic [AW-1:0]        w_nxt_pc;
    logic                 w_nxt_taken;
    logic                 w_nxt_wrap;

    always_comb begin
        w_seq       = {1'b0, r_pc} + {{AW{1'b0}}, 1'b1};
        w_seq_wraps = (w_seq >= prog_len);
        w_seq_pc    = w_seq_wraps ? '0 : w_seq[AW-1:0];
        w_jmp_pc    = ({1'b0, jmp_tgt} < prog_len) ? jmp_tgt : '0;
        w_acc_zero  = (acc == '0);

        w_cond = 1'b0;
        case (jmp_op)
            c_OP_JEZ: w_cond = w_acc_zero;
            c_OP_JNZ: w_cond = !w_acc_zero;
            c_OP_JGZ: w_cond = !acc[DW-1] && !w_acc_zero;
            c_OP_JLZ: w_cond = acc[DW-1];
            default:  w_cond = 1'b0;
        endcase

        w_s    = $signed({{(c_SW-AW){1'b0}}, r_pc})
               + $signed({{(c_SW-DW){jro_off[DW-1]}}, jro_off});
        w_last = $signed({{(c_SW-AW-1){1'b0}}, prog_len} - {{(c_SW-1){1'b0}}, 1'b1});
        if (w_s[c_SW-1])
            w_jro_pc = '0;
        else if (w_s > w_last)
            w_jro_pc = w_last[AW-1:0];
        else
            w_jro_pc = w_s[AW-1:0];

        w_nxt_pc    = w_seq_pc;
        w_nxt_taken = 1'b0;
        w_nxt_wrap  = w_seq_wraps;
        case (jmp_op)
            c_OP_JMP: begin
                w_nxt_pc    = w_jmp_pc;
                w_nxt_taken = 1'b1;
                w_nxt_wrap  = 1'b0;
            end
            c_OP_JEZ, c_OP_JNZ, c_OP_JGZ, c_OP_JLZ: begin
                if (w_cond) begin
                    w_nxt_pc    = w_jmp_pc;
                    w_nxt_taken = 1'b1;
                    w_nxt_wrap  = 1'b0;
                end
            end
            c_OP_JRO: begin
                w_nxt_pc    = w_jro_pc;
                w_nxt_taken = ({1'b0, w_jro_pc} != w_seq);
                w_nxt_wrap  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else if (load) begin
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else if (prog_len == '0) begin
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_pc    <= w_nxt_pc;
            r_taken <= w_nxt_taken;
            r_wrap  <= w_nxt_wrap;
            if (r_cnt != {CW{1'b1}})
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign pc       = r_pc;
    assign taken    = r_taken;
    assign wrap     = r_wrap;
    assign step_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tis_ip_seq.sv
// ============================================================================
//  Module      : tb_tis_ip_seq
//  Description : Self-checking bench for tis_ip_seq against an integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tis_ip_seq;

    localparam int AW = 8;
    localparam int DW = 11;

    logic          clk;
    logic          rst;
    logic          load;
    logic          en;
    logic [AW:0]   prog_len;
    logic [2:0]    jmp_op;
    logic [AW-1:0] jmp_tgt;
    logic [DW-1:0] jro_off;
    logic [DW-1:0] acc;

    logic [AW-1:0] pc;
    logic          taken;
    logic          wrap;
    logic [15:0]   step_cnt;
    logic [AW-1:0] pc4;
    logic          taken4;
    logic          wrap4;
    logic [3:0]    step_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pc, m_taken, m_wrap, m_cnt, m_cnt4;

    tis_ip_seq #(.AW(AW), .DW(DW), .CW(16)) dut (
        .clk(clk), .rst(rst), .load(load), .en(en), .prog_len(prog_len),
        .jmp_op(jmp_op), .jmp_tgt(jmp_tgt), .jro_off(jro_off), .acc(acc),
        .pc(pc), .taken(taken), .wrap(wrap), .step_cnt(step_cnt)
    );

    tis_ip_seq #(.AW(AW), .DW(DW), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .en(en), .prog_len(prog_len),
        .jmp_op(jmp_op), .jmp_tgt(jmp_tgt), .jro_off(jro_off), .acc(acc),
        .pc(pc4), .taken(taken4), .wrap(wrap4), .step_cnt(step_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_pc = 0; m_taken = 0; m_wrap = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_edge();
        int L, a, s, dst;
        bit jump, is_jro;
        L = int'(prog_len);
        if (load) begin
            model_reset();
        end else if (L == 0) begin
            m_pc = 0; m_taken = 0; m_wrap = 0;
        end else if (en) begin
            a = int'($signed(acc));
            is_jro = (jmp_op == 3'd6);
            case (jmp_op)
                3'd1: jump = 1;
                3'd2: jump = (a == 0);
                3'd3: jump = (a != 0);
                3'd4: jump = (a > 0);
                3'd5: jump = (a < 0);
                default: jump = 0;
            endcase
            if (is_jro) begin
                s = m_pc + int'($signed(jro_off));
                dst = (s < 0) ? 0 : ((s > L - 1) ? L - 1 : s);
                m_taken = (dst != m_pc + 1) ? 1 : 0;
                m_wrap = 0;
                m_pc = dst;
            end else if (jump) begin
                m_pc = (int'(jmp_tgt) < L) ? int'(jmp_tgt) : 0;
                m_taken = 1;
                m_wrap = 0;
            end else begin
                m_taken = 0;
                m_wrap = (m_pc + 1 >= L) ? 1 : 0;
                m_pc = m_wrap ? 0 : m_pc + 1;
            end
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endtask

    // One clock edge; outputs settle and are sampled 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic goto_pc(input int p);
        load = 1'b1; en = 1'b1;
        cycle();
        load = 1'b0; jmp_op = 3'd1; jmp_tgt = AW'(p);
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0; prog_len = '0; jmp_op = '0;
        jmp_tgt = '0; jro_off = '0; acc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pc !== 8'd0) begin n_errors++; $display("FAIL reset_pc got %0d want 0", pc); end
        n_checks++; if (taken !== 1'b0) begin n_errors++; $display("FAIL reset_taken got %0b want 0", taken); end
        n_checks++; if (wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap got %0b want 0", wrap); end
        n_checks++; if (step_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", step_cnt); end
    endtask

    task automatic test_wrap();
        int exp_pc[4] = '{1, 2, 0, 1};
        int exp_wr[4] = '{0, 0, 1, 0};
        prog_len = 9'd3; en = 1'b1; jmp_op = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (pc !== AW'(exp_pc[i]) || wrap !== exp_wr[i][0]) begin
                n_errors++;
                $display("FAIL wrap_step%0d got pc=%0d wrap=%0b want pc=%0d wrap=%0d", i, pc, wrap, exp_pc[i], exp_wr[i]);
            end
        end
        n_checks++; if (step_cnt !== 16'd4) begin n_errors++; $display("FAIL wrap_cnt got %0d want 4", step_cnt); end
    endtask

    task automatic test_cond();
        logic [2:0]    ops[4]  = '{3'd2, 3'd3, 3'd4, 3'd5};
        logic [DW-1:0] accs[4] = '{11'h000, 11'h000, 11'h7FF, 11'h7FF};
        int ep[4] = '{2, 6, 6, 2};
        int et[4] = '{1, 0, 0, 1};
        prog_len = 9'd10;
        for (int i = 0; i < 4; i++) begin
            goto_pc(5);
            jmp_op = ops[i]; jmp_tgt = 8'd2; acc = accs[i];
            cycle();
            n_checks++;
            if (pc !== AW'(ep[i]) || taken !== et[i][0]) begin
                n_errors++;
                $display("FAIL cond_op%0d got pc=%0d taken=%0b want pc=%0d taken=%0d", ops[i], pc, taken, ep[i], et[i]);
            end
        end
    endtask

    task automatic test_jro();
        logic [DW-1:0] offs[4] = '{11'h7F9, 11'd20, 11'd0, 11'd1};
        int ep[4] = '{0, 7, 4, 5};
        int et[4] = '{1, 1, 1, 0};
        prog_len = 9'd8;
        for (int i = 0; i < 4; i++) begin
            goto_pc(4);
            jmp_op = 3'd6; jro_off = offs[i];
            cycle();
            n_checks++;
            if (pc !== AW'(ep[i]) || taken !== et[i][0] || wrap !== 1'b0) begin
                n_errors++;
                $display("FAIL jro_%0d got pc=%0d taken=%0b wrap=%0b want pc=%0d taken=%0d wrap=0", i, pc, taken, wrap, ep[i], et[i]);
            end
        end
    endtask

    task automatic test_stall_load();
        logic [15:0] cnt0;
        prog_len = 9'd10;
        goto_pc(3);
        cnt0 = step_cnt;
        en = 1'b0; jmp_op = 3'd0;
        repeat (5) cycle();
        n_checks++;
        if (pc !== 8'd3 || taken !== 1'b1 || step_cnt !== cnt0) begin
            n_errors++;
            $display("FAIL stall got pc=%0d taken=%0b cnt=%0d want pc=3 taken=1 cnt=%0d", pc, taken, step_cnt, cnt0);
        end
        load = 1'b1; en = 1'b1; jmp_op = 3'd1; jmp_tgt = 8'd7;
        cycle();
        load = 1'b0;
        n_checks++;
        if (pc !== 8'd0 || taken !== 1'b0 || step_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL load got pc=%0d taken=%0b cnt=%0d want pc=0 taken=0 cnt=0", pc, taken, step_cnt);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] cnt0;
        prog_len = 9'd10;
        goto_pc(4);
        cnt0 = step_cnt;
        prog_len = 9'd0; en = 1'b1; jmp_op = 3'd0;
        repeat (3) cycle();
        n_checks++;
        if (pc !== 8'd0 || step_cnt !== cnt0) begin
            n_errors++;
            $display("FAIL empty_prog got pc=%0d cnt=%0d want pc=0 cnt=%0d", pc, step_cnt, cnt0);
        end
        prog_len = 9'd10;
        goto_pc(4);
        prog_len = 9'd9; jmp_op = 3'd1; jmp_tgt = 8'd9;
        cycle();
        n_checks++;
        if (pc !== 8'd0 || taken !== 1'b1) begin
            n_errors++;
            $display("FAIL jmp_oob got pc=%0d taken=%0b want pc=0 taken=1", pc, taken);
        end
        prog_len = 9'd10;
        goto_pc(6);
        prog_len = 9'd2; jmp_op = 3'd0;
        cycle();
        n_checks++;
        if (pc !== 8'd0 || wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL shrink got pc=%0d wrap=%0b want pc=0 wrap=1", pc, wrap);
        end
    endtask

    task automatic test_async_reset();
        prog_len = 9'd10;
        goto_pc(7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (pc !== 8'd0 || step_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL async_rst got pc=%0d cnt=%0d want pc=0 cnt=0", pc, step_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        prog_len = 9'd10; en = 1'b1; load = 1'b0; jmp_op = 3'd0;
        repeat (20) cycle();
        n_checks++;
        if (step_cnt4 !== 4'd15) begin n_errors++; $display("FAIL sat_cw4 got %0d want 15", step_cnt4); end
        n_checks++;
        if (step_cnt !== 16'd20) begin n_errors++; $display("FAIL sat_cw16 got %0d want 20", step_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 99) < 3);
            en   = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 10)
                prog_len = ($urandom_range(0, 19) == 0) ? 9'd0 : 9'($urandom_range(1, 256));
            jmp_op  = 3'($urandom);
            jmp_tgt = 8'($urandom);
            acc     = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom);
            jro_off = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'($urandom_range(0, 20) - 10);
            cycle();
            n_checks++;
            if (pc !== AW'(m_pc) || taken !== m_taken[0] || wrap !== m_wrap[0] || step_cnt !== 16'(m_cnt) || step_cnt4 !== 4'(m_cnt4)) begin
                n_errors++;
                $display("FAIL rand_%0d got pc=%0d t=%0b w=%0b c=%0d c4=%0d want pc=%0d t=%0d w=%0d c=%0d c4=%0d",
                         i, pc, taken, wrap, step_cnt, step_cnt4, m_pc, m_taken, m_wrap, m_cnt, m_cnt4);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_cond();
        test_jro();
        test_stall_load();
        test_boundaries();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
